host_cmd_master: RTL

HOST_CMD_MASTER -- requirements
Module: host_cmd_master

---
 rtl/host_cmd_pkg.sv | 22 ++
 rtl/host_cmd_timer.sv | 18 +
 rtl/host_cmd_master.sv | 91 +++++++++
 3 files changed

// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: command bytes, request encoding, FSM states and frame byte selection.
package host_cmd_pkg;
  typedef enum logic [1:0] {CMD_WR = 2'b00, CMD_RD = 2'b01, CMD_ALU = 2'b10, CMD_NOP = 2'b11} cmd_t;
  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_RSP, DONE} state_t;
  localparam logic [7:0] HDR_WR = 8'hAA;
  localparam logic [7:0] HDR_RD = 8'hBB;
  localparam logic [7:0] HDR_ALU = 8'hCC;
  localparam logic [7:0] HDR_NOP = 8'hDD;
  function automatic logic [1:0] last_idx(input cmd_t c);
    return c == CMD_WR ? 2'd2 : c == CMD_ALU ? 2'd3 : 2'd1;
  endfunction
  function automatic logic [7:0] frame_byte(input cmd_t c, input logic [1:0] i, input logic [3:0] addr,
                                            input logic [7:0] data, input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] fun);
    logic [7:0] hdr;
    hdr = c == CMD_WR ? HDR_WR : c == CMD_RD ? HDR_RD : c == CMD_ALU ? HDR_ALU : HDR_NOP;
    return i == 2'd0 ? hdr :
           c == CMD_WR ? (i == 2'd1 ? {4'h0, addr} : data) :
           c == CMD_RD ? {4'h0, addr} :
           c == CMD_ALU ? (i == 2'd1 ? a : i == 2'd2 ? b : {4'h0, fun}) : {4'h0, fun};
  endfunction
endpackage

// File: rtl/host_cmd_timer.sv
// host_cmd_timer: response timeout counter, flags the terminal count TIMEOUT-1.
module host_cmd_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/host_cmd_master.sv
// host_cmd_master: serialises host commands to a UART and collects the reply.
module host_cmd_master
  import host_cmd_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_cmd,
  input  logic [3:0]    req_addr,
  input  logic [7:0]    req_data,
  input  logic [7:0]    req_op_a,
  input  logic [7:0]    req_op_b,
  input  logic [3:0]    req_fun,
  output logic [DW-1:0] tx_p_data,
  output logic          tx_d_vld,
  input  logic          tx_busy,
  input  logic [DW-1:0] rx_p_data,
  input  logic          rx_d_vld,
  output logic          rsp_valid,
  output logic [15:0]   rsp_data,
  output logic          rsp_err
);
  state_t state, nxt;
  cmd_t cmd;
  logic [3:0] addr, fun;
  logic [7:0] data, op_a, op_b;
  logic [1:0] idx;
  logic rx_cnt, last, rx_take, rx_done, timed_out, t_clear, expired;
  assign last = idx == last_idx(cmd);
  assign rx_take = state == WAIT_RSP && rx_d_vld;
  assign rx_done = rx_take && (cmd == CMD_RD || rx_cnt);
  // a byte arriving on the terminal count wins over the timeout
  assign timed_out = state == WAIT_RSP && expired && !rx_d_vld;
  assign t_clear = (state == GAP && last) || rx_take;
  assign req_ready = state == IDLE && !rst;
  assign rsp_valid = state == DONE;
  assign tx_p_data = tx_d_vld ? DW'(frame_byte(cmd, idx, addr, data, op_a, op_b, fun)) : '0;
  host_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clear(t_clear), .enable(state == WAIT_RSP), .expired(expired)
  );
  always_comb begin
    nxt = state;
    tx_d_vld = 1'b0;
    case (state)
      IDLE: nxt = req_valid && req_ready ? SEND : IDLE;
      SEND: begin
        tx_d_vld = !tx_busy;
        nxt = tx_busy ? SEND : GAP;
      end
      GAP: nxt = !last ? SEND : cmd == CMD_WR ? DONE : WAIT_RSP;
      WAIT_RSP: nxt = rx_done || timed_out ? DONE : WAIT_RSP;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cmd <= CMD_WR;
      {addr, fun, data, op_a, op_b} <= '0;
      idx <= '0;
      rx_cnt <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        cmd <= cmd_t'(req_cmd);
        addr <= req_addr;
        data <= req_data;
        op_a <= req_op_a;
        op_b <= req_op_b;
        fun <= req_fun;
        idx <= '0;
        rx_cnt <= 1'b0;
        rsp_data <= '0;
        rsp_err <= 1'b0;
      end
      if (state == GAP && !last) idx <= idx + 2'd1;
      if (rx_take) begin
        rx_cnt <= 1'b1;
        if (rx_cnt) rsp_data[15:8] <= rx_p_data[7:0];
        else rsp_data[7:0] <= rx_p_data[7:0];
      end
      if (timed_out) rsp_err <= 1'b1;
    end
endmodule
